// File: rtl/prog_loader_pkg.sv
// Shared definitions for the serial program loader: frame states,
// default parameters and the running checksum helper.
package prog_loader_pkg;

  localparam int          ADDR_W_DEF    = 10;
  localparam int          DATA_W_DEF    = 18;
  localparam int          BYTE_W        = 8;
  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam int          TIMEOUT_DEF   = 1_000_000;

  // One state per frame field; W2/W1/W0 repeat once per instruction word.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_AH,
    ST_AL,
    ST_LH,
    ST_LL,
    ST_W2,
    ST_W1,
    ST_W0,
    ST_CS
  } state_e;

  // Modulo-256 accumulation used for the frame checksum.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/prog_loader_timer.sv
// Inter-byte idle timer. Counts enabled clocks since the last clear and
// pulses expire_o on the TIMEOUT-th idle clock, then restarts from zero.
module loader_timer
  import prog_loader_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q;

  // A clear in the same cycle wins over expiry: a byte arriving on the last
  // allowed clock still counts as in time.
  assign expire_o = en_i && !clr_i && (count_q == CNT_W'(TIMEOUT - 1));

  // Idle-clock counter, restarted by every received byte and by expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr_i || expire_o) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: parses SYNC/ADDR/LEN/words/CSUM frames from a byte
// stream, writes assembled instructions into the program RAM and holds the
// CPU in reset while a frame is in flight or after a failed load.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         ADDR_W    = ADDR_W_DEF,
  parameter int         DATA_W    = DATA_W_DEF,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         TIMEOUT   = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;       // next RAM address to write
  logic [ADDR_W-1:0] cnt_q;       // words remaining minus one
  logic [7:0]        b2_q;        // holds ADDR_H / LEN_H / B2 until the low byte arrives
  logic [7:0]        b1_q;
  logic [7:0]        csum_q;
  logic [7:0]        csum_d;

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              cpu_reset_q;
  logic              done_q;
  logic              error_q;

  logic              tmr_expire;

  assign csum_d = csum_add(csum_q, rx_data);

  // Timer only runs inside a frame; every strobe restarts it.
  loader_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (rx_valid),
    .en_i     (state_q != ST_IDLE),
    .expire_o (tmr_expire)
  );

  // Frame parser with registered outputs; wr_en and done are 1-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      b2_q        <= '0;
      b1_q        <= '0;
      csum_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cpu_reset_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      if (tmr_expire) begin
        // Abandoned frame: keep the core parked, flag it.
        state_q <= ST_IDLE;
        error_q <= 1'b1;
      end else if (rx_valid) begin
        if (state_q != ST_IDLE) begin
          csum_q <= csum_d;
        end
        unique case (state_q)
          ST_IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              state_q     <= ST_AH;
              cpu_reset_q <= 1'b1;
              error_q     <= 1'b0;
              csum_q      <= '0;
            end
          end
          ST_AH: begin
            b2_q    <= rx_data;
            state_q <= ST_AL;
          end
          ST_AL: begin
            // Truncation keeps only the low ADDR_W bits of {ADDR_H, ADDR_L}.
            ptr_q   <= ADDR_W'({b2_q, rx_data});
            state_q <= ST_LH;
          end
          ST_LH: begin
            b2_q    <= rx_data;
            state_q <= ST_LL;
          end
          ST_LL: begin
            cnt_q   <= ADDR_W'({b2_q, rx_data});
            state_q <= ST_W2;
          end
          ST_W2: begin
            b2_q    <= rx_data;
            state_q <= ST_W1;
          end
          ST_W1: begin
            b1_q    <= rx_data;
            state_q <= ST_W0;
          end
          ST_W0: begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= ptr_q;
            wr_data_q <= DATA_W'({b2_q, b1_q, rx_data});
            ptr_q     <= ptr_q + 1'b1;   // wraps silently at the top of RAM
            if (cnt_q == '0) begin
              state_q <= ST_CS;
            end else begin
              cnt_q   <= cnt_q - 1'b1;
              state_q <= ST_W2;
            end
          end
          ST_CS: begin
            state_q <= ST_IDLE;
            if (csum_d == 8'h00) begin
              done_q      <= 1'b1;
              cpu_reset_q <= 1'b0;
            end else begin
              error_q     <= 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
